// File: rtl/core_pkg.sv
// core_pkg: shared run-control types, select codes and instruction constants for the fetch front end
package core_pkg;
    localparam int DEF_PC_WIDTH = 7;
    localparam int DEF_INSTR_WIDTH = 32;
    localparam logic [31:0] CORE_NOP_WORD = 32'h0000_0000;
    localparam logic [31:0] CORE_HALT_WORD = 32'hFFFF_FFFF;
    typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, HALTED = 2'b10} state_t;
    typedef enum logic [2:0] {SEL_SEQ, SEL_STALL, SEL_HALT, SEL_BRANCH, SEL_JUMP} pc_sel_t;
endpackage

// File: rtl/fetch_next_pc.sv
// fetch_next_pc: prioritised next-pc selection (branch > jump > stall > halt > pc+1)
module fetch_next_pc
    import core_pkg::*;
#(
    parameter int PC_WIDTH = DEF_PC_WIDTH
) (
    input  logic [PC_WIDTH-1:0] pc,
    input  logic                branch_taken,
    input  logic [PC_WIDTH-1:0] branch_target,
    input  logic                jump,
    input  logic [PC_WIDTH-1:0] jump_target,
    input  logic                stall,
    input  logic                halt_detect,
    output logic [PC_WIDTH-1:0] pc_inc,
    output logic [PC_WIDTH-1:0] next_pc,
    output pc_sel_t             sel
);
    always_comb begin
        pc_inc = pc + PC_WIDTH'(1);
        sel = branch_taken ? SEL_BRANCH : jump ? SEL_JUMP : stall ? SEL_STALL : halt_detect ? SEL_HALT : SEL_SEQ;
        next_pc = branch_taken ? branch_target : jump ? jump_target : (stall || halt_detect) ? pc : pc_inc;
    end
endmodule

// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit: PC register, IF/ID capture and IDLE/RUN/HALTED run control
module fetch_pc_unit
    import core_pkg::*;
#(
    parameter int                     PC_WIDTH    = DEF_PC_WIDTH,
    parameter int                     INSTR_WIDTH = DEF_INSTR_WIDTH,
    parameter logic [PC_WIDTH-1:0]    RESET_PC    = '0,
    parameter logic [INSTR_WIDTH-1:0] HALT_WORD   = CORE_HALT_WORD,
    parameter logic [INSTR_WIDTH-1:0] NOP_WORD    = CORE_NOP_WORD
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   stall,
    input  logic                   branch_taken,
    input  logic [PC_WIDTH-1:0]    branch_target,
    input  logic                   jump,
    input  logic [PC_WIDTH-1:0]    jump_target,
    output logic [PC_WIDTH-1:0]    imem_addr,
    input  logic [INSTR_WIDTH-1:0] imem_data,
    output logic [PC_WIDTH-1:0]    pc,
    output logic [INSTR_WIDTH-1:0] if_id_instr,
    output logic [PC_WIDTH-1:0]    if_id_pc_next,
    output logic                   if_id_valid,
    output logic                   halted
);
    state_t state, state_nxt;
    pc_sel_t sel;
    logic [PC_WIDTH-1:0] pc_inc, next_pc, pc_d, pc_next_d;
    logic [INSTR_WIDTH-1:0] instr_d;
    logic active, redirect, capture, hold, valid_d;

    assign imem_addr = pc;
    assign halted = state == HALTED;
    assign active = state != IDLE;

    // redirects are masked in IDLE; in HALTED the pc is held as if a halt were seen
    fetch_next_pc #(.PC_WIDTH(PC_WIDTH)) u_next_pc (
        .pc           (pc),
        .branch_taken (branch_taken && active),
        .branch_target(branch_target),
        .jump         (jump && active),
        .jump_target  (jump_target),
        .stall        (stall),
        .halt_detect  (halted || imem_data == HALT_WORD),
        .pc_inc       (pc_inc),
        .next_pc      (next_pc),
        .sel          (sel)
    );

    always_comb begin
        redirect = sel == SEL_BRANCH || sel == SEL_JUMP;
        hold = active && sel == SEL_STALL;
        capture = state == RUN && (sel == SEL_SEQ || sel == SEL_HALT);
        pc_d = active ? next_pc : pc;
        state_nxt = state == IDLE ? (start ? RUN : IDLE) : redirect ? RUN : (state == RUN && sel == SEL_HALT) ? HALTED : state;
        instr_d = capture ? imem_data : hold ? if_id_instr : NOP_WORD;
        pc_next_d = capture ? pc_inc : hold ? if_id_pc_next : '0;
        valid_d = capture || (hold && if_id_valid);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            pc <= RESET_PC;
            if_id_instr <= NOP_WORD;
            if_id_pc_next <= '0;
            if_id_valid <= 1'b0;
        end else begin
            state <= state_nxt;
            pc <= pc_d;
            if_id_instr <= instr_d;
            if_id_pc_next <= pc_next_d;
            if_id_valid <= valid_d;
        end
    end
endmodule

// File: tb/tb_fetch_pc_unit.sv
// tb_fetch_pc_unit: scoreboard bench with a behavioural fetch model
module tb_fetch_pc_unit;
    localparam logic [31:0] HALT = 32'hFFFF_FFFF;

    typedef struct packed {
        logic [6:0]  pc;
        logic [31:0] instr;
        logic [6:0]  pcn;
        logic        valid;
        logic        halted;
    } exp_t;

    logic clk = 1'b0;
    logic reset, start, stall, branch_taken, jump;
    logic [6:0] branch_target, jump_target, imem_addr, pc, if_id_pc_next;
    logic [31:0] imem_data, if_id_instr;
    logic if_id_valid, halted;
    logic [31:0] imem [128];

    int total = 0;
    int bad = 0;
    exp_t q[$];
    int m_state = 0;
    logic [6:0] m_pc = '0;
    logic [31:0] m_instr = '0;
    logic [6:0] m_pcn = '0;
    logic m_valid = 1'b0;

    always #5 clk = ~clk;
    assign imem_data = imem[imem_addr];

    fetch_pc_unit dut (
        .clk(clk), .reset(reset), .start(start), .stall(stall),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .jump(jump), .jump_target(jump_target), .imem_addr(imem_addr),
        .imem_data(imem_data), .pc(pc), .if_id_instr(if_id_instr),
        .if_id_pc_next(if_id_pc_next), .if_id_valid(if_id_valid), .halted(halted)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input logic rst, input logic st, input logic sl,
                        input logic br, input logic [6:0] bt, input logic jp, input logic [6:0] jt);
        exp_t e, g;
        @(negedge clk);
        reset = rst; start = st; stall = sl;
        branch_taken = br; branch_target = bt; jump = jp; jump_target = jt;
        check("imem_addr", {25'd0, imem_addr}, {25'd0, m_pc});
        e = '{pc: m_pc, instr: m_instr, pcn: m_pcn, valid: m_valid, halted: 1'b0};
        if (rst) begin
            m_state = 0;
            e = '{pc: 7'd0, instr: 32'd0, pcn: 7'd0, valid: 1'b0, halted: 1'b0};
        end else if (m_state == 0) begin
            if (st) m_state = 1;
            e.instr = 32'd0; e.pcn = 7'd0; e.valid = 1'b0;
        end else if (br || jp) begin
            m_state = 1;
            e.pc = br ? bt : jt;
            e.instr = 32'd0; e.pcn = 7'd0; e.valid = 1'b0;
        end else if (sl) begin
        end else if (m_state == 2) begin
            e.instr = 32'd0; e.pcn = 7'd0; e.valid = 1'b0;
        end else begin
            e.instr = imem[m_pc];
            e.pcn = m_pc + 7'd1;
            e.valid = 1'b1;
            if (imem[m_pc] == HALT) m_state = 2;
            else e.pc = m_pc + 7'd1;
        end
        e.halted = m_state == 2;
        m_pc = e.pc; m_instr = e.instr; m_pcn = e.pcn; m_valid = e.valid;
        q.push_back(e);
        @(posedge clk);
        #1;
        g = q.pop_front();
        check("pc", {25'd0, pc}, {25'd0, g.pc});
        check("if_id_instr", if_id_instr, g.instr);
        check("if_id_pc_next", {25'd0, if_id_pc_next}, {25'd0, g.pcn});
        check("if_id_valid", {31'd0, if_id_valid}, {31'd0, g.valid});
        check("halted", {31'd0, halted}, {31'd0, g.halted});
    endtask

    task automatic idle_steps(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 7'd0, 0, 7'd0);
    endtask

    initial begin
        for (int i = 0; i < 128; i++) imem[i] = 32'hC000_0000 | i;
        imem[0] = 32'h11; imem[1] = 32'h22; imem[2] = 32'h33; imem[3] = 32'h44;
        imem[8] = HALT; imem[127] = 32'hAB;
        reset = 1; start = 0; stall = 0; branch_taken = 0; jump = 0;
        branch_target = '0; jump_target = '0;
        step(1, 0, 0, 0, 7'd0, 0, 7'd0);
        step(1, 0, 0, 0, 7'd0, 0, 7'd0);
        step(0, 0, 1, 0, 7'd0, 1, 7'd9);
        step(0, 1, 0, 0, 7'd0, 0, 7'd0);
        idle_steps(5);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 7'd0, 0, 7'd0);
        check("stall_pc", {25'd0, pc}, 32'd5);
        idle_steps(1);
        check("stall_release_instr", if_id_instr, 32'hC000_0005);
        idle_steps(3);
        check("halt_instr", if_id_instr, HALT);
        check("halt_pcn", {25'd0, if_id_pc_next}, 32'd9);
        check("halt_pc", {25'd0, pc}, 32'd8);
        idle_steps(1);
        step(0, 0, 1, 0, 7'd0, 0, 7'd0);
        step(0, 1, 0, 0, 7'd0, 0, 7'd0);
        step(0, 0, 0, 1, 7'd3, 0, 7'd0);
        check("resume_halted", {31'd0, halted}, 32'd0);
        idle_steps(5);
        step(0, 0, 1, 0, 7'd0, 0, 7'd0);
        idle_steps(1);
        step(0, 0, 0, 0, 7'd0, 1, 7'd127);
        idle_steps(1);
        check("wrap_instr", if_id_instr, 32'hAB);
        check("wrap_pcn", {25'd0, if_id_pc_next}, 32'd0);
        check("wrap_pc", {25'd0, pc}, 32'd0);
        idle_steps(2);
        step(0, 0, 1, 1, 7'd40, 1, 7'd20);
        check("both_redirect_pc", {25'd0, pc}, 32'd40);
        idle_steps(1);
        check("after_redirect_instr", if_id_instr, 32'hC000_0028);
        step(0, 0, 0, 0, 7'd0, 1, 7'd50);
        step(0, 0, 1, 0, 7'd0, 0, 7'd0);
        step(1, 1, 1, 0, 7'd0, 0, 7'd0);
        idle_steps(2);
        step(0, 1, 0, 0, 7'd0, 0, 7'd0);
        idle_steps(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
